bc_io_intr_ctrl: RTL
====================

# bc_io_intr_ctrl

I/O and interrupt sequencer for the basic computer.
- Owns the input/output device registers (INPR, OUTR), the device flags (FGI, FGO), and the interrupt flip-flops (IEN, R).
- Sits beside the main controller. The controller reports when an I/O instruction executes and where the sequence counter is. This block returns flag state, skip decisions, the interrupt request and input data for AC.

## Interface
Parameters:
- DATA_W, default 8: character width of INPR/OUTR.
- OUT_DELAY, default 4: cycles the output device stays busy after a handshake before FGO sets. 0 is legal.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input device presents a character.
- in_data  in  DATA_W  character from the input device.
- in_ready  out  1  equals ~FGI.
- out_valid  out  1  OUTR holds a character for the output device.
- out_data  out  DATA_W  equals OUTR.
- out_ready  in  1  output device accepts the character.
- io_exec  in  1  one-cycle pulse: controller executes a register-I/O instruction (D7·I·T3).
- ir_io  in  6  IR[11:6]; bit5 INP, bit4 OUT, bit3 SKI, bit2 SKO, bit1 ION, bit0 IOF.
- ac_low  in  DATA_W  AC[DATA_W-1:0].
- sc_t012  in  1  sequence counter is in T0, T1 or T2.
- intr_done  in  1  one-cycle pulse in the interrupt cycle's R·T2.
- inp_load  out  1  io_exec & ir_io[5]; controller loads inpr into AC low bits.
- inpr  out  DATA_W  INPR register.
- skip  out  1  io_exec & ((ir_io[3] & FGI) | (ir_io[2] & FGO)); controller increments PC.
- fgi, fgo, ien, r_ff  out  1 each  flag/flip-flop state.

## Operation
Reset values:
- IEN=0, R=0, FGI=0, INPR=0, OUTR=0.
- Output FSM in O_READY (so FGO=1), out_valid=0.
- in_ready=1; skip=0 and inp_load=0 because io_exec is low.

Input path:
- Accept on in_valid & in_ready: INPR<=in_data, FGI<=1.
- INP (io_exec & ir_io[5]) clears FGI at that edge.
- in_ready is derived from registered FGI, so a character offered in the same cycle as INP is accepted one cycle later.

Output FSM (states O_READY, O_SEND, O_BUSY); FGO = (state==O_READY):
- O_READY + OUT exec: OUTR<=ac_low, go to O_SEND.
- O_SEND: out_valid=1. On out_ready, go to O_BUSY with count=OUT_DELAY, or straight to O_READY if OUT_DELAY=0.
- O_BUSY: count decrements each cycle. At count==1, go to O_READY.
- OUT executed while FGO=0 is ignored: OUTR and state unchanged.

Flags and interrupts:
- ION sets IEN; IOF clears it. If both bits are set, IOF wins.
- Multiple ir_io bits may be set together; each executes in the same cycle.
- R sets at an edge when ien & (fgi|fgo) & ~sc_t012 & ~r_ff.
- intr_done clears R and IEN. It takes priority over R set and over ION in the same cycle.
- io_exec is ignored when ir_io==0.

## Timing
- skip and inp_load are combinational from io_exec and registered flags. Zero latency, valid in the io_exec cycle.
- Flag updates from INP, ION and IOF are visible the cycle after io_exec.
- OUT at edge k: out_valid=1 and FGO=0 after edge k.
- Handshake sampled at edge m: out_valid=0 after m; FGO=1 after edge m+OUT_DELAY.
- R is visible one cycle after its set condition holds. The set condition is masked while sc_t012=1.
- rst_n deassertion is asynchronous-assert / synchronous-release at the top level. Reset mid-handshake drops out_valid immediately and restores FGO=1.

## Structure
- Package bc_io_pkg holds:
  - the output-state enum (O_READY, O_SEND, O_BUSY);
  - ir_io bit-index constants (IO_INP=5, IO_OUT=4, IO_SKI=3, IO_SKO=2, IO_ION=1, IO_IOF=0).
- Sub-module bc_out_port holds OUTR, the output FSM and the delay counter (counter width $clog2(OUT_DELAY+1), minimum 1). It exports fgo and accepts an out_load strobe.
- The top holds INPR, FGI, IEN, R and the combinational skip/inp_load logic.

## Test plan
- Reset, then check idle outputs: fgo=1, fgi=0, ien=0, r_ff=0, in_ready=1, out_valid=0.
- Input path:
  - Drive in_valid with in_data=0x41 → fgi=1, inpr=0x41, in_ready=0.
  - SKI exec → skip=1.
  - INP exec → inp_load=1, then fgi=0.
- Output path with OUT_DELAY=4, ac_low=0x5A:
  - OUT exec → out_valid=1, out_data=0x5A, fgo=0.
  - Hold out_ready=0 for 3 cycles → out_valid stays 1.
  - Handshake at edge m → fgo=1 after m+4.
  - SKO during busy → skip=0.
- Interrupt:
  - ION exec with fgo=1 and sc_t012=0 → ien=1 next cycle, r_ff=1 the cycle after.
  - With sc_t012=1, r_ff stays 0.
  - intr_done → r_ff=0, ien=0.
- Simultaneous events:
  - in_valid in the same cycle as INP exec with fgi=1 → character accepted exactly one cycle later.
  - ION+IOF together → ien=0.
  - intr_done with ION → ien=0.
- Misuse and reset:
  - OUT while fgo=0 → OUTR unchanged.
  - rst_n pulsed low during O_SEND → out_valid=0 and fgo=1 asynchronously.

Source files
------------

// File: rtl/bc_io_intr_ctrl_pkg.sv
// Shared definitions for the basic-computer I/O and interrupt sequencer.
// This file holds the output-port state encoding and the bit positions of the
// register-I/O opcodes in IR[11:6].
package bc_io_pkg;

  // States of the output device handshake.
  typedef enum logic [1:0] {
    O_READY = 2'd0,
    O_SEND  = 2'd1,
    O_BUSY  = 2'd2
  } out_state_t;

  // Width of the I/O opcode field taken from IR[11:6].
  localparam int IR_IO_W = 6;

  // Bit positions of the individual I/O opcodes within that field.
  localparam int IO_INP = 5;
  localparam int IO_OUT = 4;
  localparam int IO_SKI = 3;
  localparam int IO_SKO = 2;
  localparam int IO_ION = 1;
  localparam int IO_IOF = 0;

endpackage

// File: rtl/bc_io_intr_ctrl_if.sv
// Character handshake between the I/O sequencer and the external devices.
// The device side uses the master modport and the sequencer uses the slave
// modport.
interface bc_io_intr_ctrl_if #(
  parameter int DATA_W = 8
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/bc_io_intr_ctrl_out_port.sv
// Output device port: the OUTR register, the handshake FSM and the busy
// delay counter. FGO is high exactly while the FSM sits in O_READY.
module bc_out_port
  import bc_io_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int OUT_DELAY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              out_load,
  input  logic [DATA_W-1:0] ac_low,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              fgo
);

  // A zero delay still needs a one-bit counter so the declarations stay legal.
  localparam int CNT_W = (OUT_DELAY == 0) ? 1 : $clog2(OUT_DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(OUT_DELAY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  out_state_t        state;
  out_state_t        state_next;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              load_outr;
  logic [DATA_W-1:0] outr;

  // State, busy counter and OUTR registers; OUTR only changes when a load is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= O_READY;
      count <= '0;
      outr  <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (load_outr) begin
        outr <= ac_low;
      end
    end
  end

  // Next-state logic; an OUT request outside O_READY is simply dropped.
  always_comb begin
    state_next = state;
    count_next = count;
    load_outr  = 1'b0;
    case (state)
      O_READY: begin
        if (out_load) begin
          load_outr  = 1'b1;
          state_next = O_SEND;
        end
      end
      O_SEND: begin
        if (out_ready) begin
          if (OUT_DELAY == 0) begin
            state_next = O_READY;
          end else begin
            state_next = O_BUSY;
            count_next = CNT_INIT;
          end
        end
      end
      O_BUSY: begin
        count_next = count - CNT_ONE;
        if (count == CNT_ONE) begin
          state_next = O_READY;
        end
      end
      default: begin
        state_next = O_READY;
      end
    endcase
  end

  assign out_valid = (state == O_SEND);
  assign fgo       = (state == O_READY);
  assign out_data  = outr;

endmodule

// File: rtl/bc_io_intr_ctrl.sv
// I/O and interrupt sequencer for the basic computer. Owns INPR, FGI, IEN and
// R, and delegates OUTR/FGO to bc_out_port. Skip and INP-load decisions are
// combinational so the controller can act on them in the io_exec cycle.
module bc_io_intr_ctrl
  import bc_io_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int OUT_DELAY = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  bc_io_intr_ctrl_if.slave   dev,
  input  logic               io_exec,
  input  logic [IR_IO_W-1:0] ir_io,
  input  logic [DATA_W-1:0]  ac_low,
  input  logic               sc_t012,
  input  logic               intr_done,
  output logic               inp_load,
  output logic [DATA_W-1:0]  inpr,
  output logic               skip,
  output logic               fgi,
  output logic               fgo,
  output logic               ien,
  output logic               r_ff
);

  logic [1:0] rst_sync;
  logic       rst_int_n;
  logic       in_accept;
  logic       exec_inp;
  logic       exec_out;
  logic       exec_ion;
  logic       exec_iof;
  logic       r_set;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync[1];

  assign exec_inp  = io_exec & ir_io[IO_INP];
  assign exec_out  = io_exec & ir_io[IO_OUT];
  assign exec_ion  = io_exec & ir_io[IO_ION];
  assign exec_iof  = io_exec & ir_io[IO_IOF];
  assign in_accept = dev.in_valid & ~fgi;
  assign r_set     = ien & (fgi | fgo) & ~sc_t012 & ~r_ff;

  // INPR captures a character when the input device is accepted; FGI follows it.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      inpr <= '0;
      fgi  <= 1'b0;
    end else begin
      if (in_accept) begin
        inpr <= dev.in_data;
      end
      fgi <= in_accept | (fgi & ~exec_inp);
    end
  end

  // Interrupt enable and request; the end of the interrupt cycle overrides everything.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      ien  <= 1'b0;
      r_ff <= 1'b0;
    end else begin
      if (intr_done) begin
        ien  <= 1'b0;
        r_ff <= 1'b0;
      end else begin
        if (exec_iof) begin
          ien <= 1'b0;
        end else if (exec_ion) begin
          ien <= 1'b1;
        end
        if (r_set) begin
          r_ff <= 1'b1;
        end
      end
    end
  end

  bc_out_port #(
    .DATA_W    (DATA_W),
    .OUT_DELAY (OUT_DELAY)
  ) u_out_port (
    .clk       (clk),
    .rst_n     (rst_int_n),
    .out_load  (exec_out),
    .ac_low    (ac_low),
    .out_ready (dev.out_ready),
    .out_valid (dev.out_valid),
    .out_data  (dev.out_data),
    .fgo       (fgo)
  );

  assign dev.in_ready = ~fgi;
  assign inp_load     = exec_inp;
  assign skip         = io_exec & ((ir_io[IO_SKI] & fgi) | (ir_io[IO_SKO] & fgo));

endmodule
